// File: rtl/arbitro_pkg.sv
// arbitro_pkg: shared state/requester types and default widths for the memory arbiter.
package arbitro_pkg;
    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    typedef enum logic [2:0] {IDLE, GNT_CPU, GNT_LD, RESP_CPU, RESP_LD} state_t;
    typedef enum logic {REQ_CPU, REQ_LD} req_t;
endpackage

// File: rtl/arbitro_memoria_seletor_rr.sv
// seletor_rr: two-way round-robin pick; on a tie the side that was not granted last wins.
module seletor_rr
    import arbitro_pkg::*;
(
    input  logic elig_cpu_i,
    input  logic elig_ld_i,
    input  req_t last_grant_i,
    output req_t grant_o,
    output logic valid_o
);
    always_comb begin
        valid_o = elig_cpu_i | elig_ld_i;
        grant_o = (elig_cpu_i && elig_ld_i) ? ((last_grant_i == REQ_CPU) ? REQ_LD : REQ_CPU)
                : (elig_cpu_i ? REQ_CPU : REQ_LD);
    end
endmodule

// File: rtl/arbitro_memoria.sv
// arbitro_memoria: shares one synchronous memory between CPU and loader, 3 cycles per access.
module arbitro_memoria
    import arbitro_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              ld_ack,
    input  logic              ld_lock,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_t            state_q, state_d;
    req_t              last_q, last_d, grant;
    logic              valid, we_q, we_d;
    logic [DATA_W-1:0] cpu_rd_q, cpu_rd_d, ld_rd_q, ld_rd_d;

    seletor_rr u_sel (
        .elig_cpu_i   (cpu_req & ~ld_lock),
        .elig_ld_i    (ld_req),
        .last_grant_i (last_q),
        .grant_o      (grant),
        .valid_o      (valid)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        we_d      = we_q;
        cpu_rd_d  = cpu_rd_q;
        ld_rd_d   = ld_rd_q;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: if (valid) state_d = (grant == REQ_CPU) ? GNT_CPU : GNT_LD;
            GNT_CPU: begin
                state_d   = RESP_CPU;
                last_d    = REQ_CPU;
                we_d      = cpu_we;
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
            end
            GNT_LD: begin
                state_d   = RESP_LD;
                last_d    = REQ_LD;
                we_d      = ld_we;
                mem_addr  = ld_addr;
                mem_wdata = ld_wdata;
                mem_we    = ld_we;
            end
            RESP_CPU: begin
                state_d  = IDLE;
                cpu_rd_d = we_q ? cpu_rd_q : mem_rdata;
            end
            RESP_LD: begin
                state_d = IDLE;
                ld_rd_d = we_q ? ld_rd_q : mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    // The write flag is latched in GNT so a request dropped mid-access cannot turn a write into a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= REQ_LD;
            we_q     <= 1'b0;
            cpu_rd_q <= '0;
            ld_rd_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            we_q     <= we_d;
            cpu_rd_q <= cpu_rd_d;
            ld_rd_q  <= ld_rd_d;
        end
    end

    assign cpu_ack   = state_q == RESP_CPU;
    assign ld_ack    = state_q == RESP_LD;
    assign cpu_rdata = cpu_rd_d;
    assign ld_rdata  = ld_rd_d;
    assign cpu_stall = cpu_req & ~cpu_ack;
endmodule
